// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the Common Data Bus arbiter slice.
package cdb_arbiter_pkg;

  localparam int CDB_ROB_SIZE = 32;
  localparam int CDB_TAG_W    = $clog2(CDB_ROB_SIZE);
  localparam int CDB_XLEN     = 32;
  localparam int CDB_NUM_REQ  = 3;

  // Requester indices on the CDB.
  localparam int FU_ALU0 = 0;
  localparam int FU_ALU1 = 1;
  localparam int FU_MEM  = 2;

  // One broadcast as seen by reservation stations and the ROB.
  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_XLEN-1:0]  value;
  } cdb_packet_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins.
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  // Walk the requests from ptr upward, wrapping, and grant the first one found.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a value unassigned (no latch).
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (gnt == '0 && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry holding buffer per FU, round-robin pick,
// registered broadcast to reservation stations and the ROB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = CDB_NUM_REQ,
  parameter  int TAG_W   = CDB_TAG_W,
  parameter  int XLEN    = CDB_XLEN,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       fu_valid,
  input  logic [NUM_REQ*TAG_W-1:0] fu_tag,
  input  logic [NUM_REQ*XLEN-1:0]  fu_value,
  output logic [NUM_REQ-1:0]       fu_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [XLEN-1:0]          cdb_value,
  output logic [SRC_W-1:0]         cdb_src
);

  logic [NUM_REQ-1:0] hold_valid;
  logic [TAG_W-1:0]   hold_tag   [NUM_REQ];
  logic [XLEN-1:0]    hold_value [NUM_REQ];
  logic [SRC_W-1:0]   rr_ptr;

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               any_grant;
  logic [NUM_REQ-1:0] accept;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (hold_valid),
    .ptr     (rr_ptr),
    .gnt     (grant),
    .gnt_idx (grant_idx)
  );

  // A buffer can take a new result when it is empty or is draining this cycle.
  always_comb begin
    any_grant = |grant;
    fu_ready  = {NUM_REQ{!flush}} & (~hold_valid | grant);
    accept    = fu_valid & fu_ready;
  end

  // Control state: buffer occupancy, round-robin pointer and the CDB register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      hold_valid <= '0;
      rr_ptr     <= '0;
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
      cdb_src    <= '0;
    end else if (flush) begin
      hold_valid <= '0;
      cdb_valid  <= 1'b0;
    end else begin
      cdb_valid <= any_grant;
      if (any_grant) begin
        cdb_tag               <= hold_tag[grant_idx];
        cdb_value             <= hold_value[grant_idx];
        cdb_src               <= grant_idx;
        hold_valid[grant_idx] <= 1'b0;
        rr_ptr                <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
      end
      // A new result landing in the same buffer overrides the drain above.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) hold_valid[i] <= 1'b1;
      end
    end
  end

  // Payload capture; contents are only meaningful while the matching hold_valid is set.
  always_ff @(posedge clock) begin
    // NOTE: payload storage is deliberately not reset; hold_valid alone qualifies it.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        hold_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
        hold_value[i] <= fu_value[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus between NUM_REQ completing functional units (ALU0, ALU1, MEM by default).
- Each FU result lands in a one-entry holding buffer. A round-robin arbiter picks one buffered result per cycle and drives it onto a registered CDB output.
- The CDB output is consumed by the reservation stations (tag wakeup, entry free) and the ROB.
- Back-pressure to FUs is a valid/ready handshake per requester.

Parameters:
- NUM_REQ, 3, number of FU result requesters; index 0 = ALU0, 1 = ALU1, 2 = MEM.
- TAG_W, 5, ROB tag width, equal to $clog2(ROB_SIZE).
- XLEN, 32, result value width.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-low (0 = reset asserted), sampled on posedge clock.
- flush  in  1  mispredict squash; discards all buffered and in-flight results.
- fu_valid  in  NUM_REQ  per-FU result valid.
- fu_tag  in  NUM_REQ*TAG_W  per-FU ROB tag, requester i at bits [i*TAG_W +: TAG_W].
- fu_value  in  NUM_REQ*XLEN  per-FU result, requester i at bits [i*XLEN +: XLEN].
- fu_ready  out  NUM_REQ  per-FU accept; a transfer occurs when fu_valid[i] && fu_ready[i].
- cdb_valid  out  1  CDB broadcast valid (registered).
- cdb_tag  out  TAG_W  broadcast ROB tag (registered).
- cdb_value  out  XLEN  broadcast value (registered).
- cdb_src  out  $clog2(NUM_REQ)  index of the winning requester (registered).

Behaviour:
- State:
  - hold_valid[i], hold_tag[i], hold_value[i] for each requester.
  - rr_ptr, $clog2(NUM_REQ) bits.
  - CDB output register.
- Reset (reset==0 at posedge):
  - hold_valid = 0, rr_ptr = 0.
  - cdb_valid = 0, cdb_tag = 0, cdb_value = 0, cdb_src = 0.
  - Reset overrides flush and all other inputs.
- Arbitration (combinational each cycle):
  - Search hold_valid starting at index rr_ptr, ascending, wrapping modulo NUM_REQ.
  - The first set entry wins: grant[i] is one-hot, or all zero if no hold_valid.
- fu_ready[i] = !flush && (!hold_valid[i] || grant[i]). This allows one result per cycle per FU when that FU wins every cycle.
- Posedge, no reset, no flush:
  - If any grant: cdb_* <= winner's hold entry and cdb_src <= winner index; hold_valid[winner] <= 0; rr_ptr <= (winner+1) mod NUM_REQ.
  - If no grant: cdb_valid <= 0; cdb_tag, cdb_value and cdb_src hold their value; rr_ptr unchanged.
  - For each i with fu_valid[i] && fu_ready[i]: hold entry i <= {1, fu_tag[i], fu_value[i]}. This write takes precedence over the grant clear in the same cycle.
- Latency:
  - Result accepted at edge t is eligible in cycle t+1.
  - With no contention, cdb_valid is high in cycle t+2.
  - Worst-case wait after entering hold is NUM_REQ cycles (round-robin bound, no starvation).
- Flush (flush==1 at posedge):
  - hold_valid <= 0 and cdb_valid <= 0.
  - FU inputs that cycle are not accepted (fu_ready = 0).
  - rr_ptr unchanged.
  - cdb_valid is 0 in the cycle after flush.
- Widths: no arithmetic on tag or value; they pass through unmodified. Tag 0 is broadcast like any other tag.
- cdb_valid is high for exactly one cycle per granted result. Each accepted result is broadcast exactly once unless flushed.
- Held FU (fu_valid=1, fu_ready=0): the FU keeps fu_tag and fu_value stable; the arbiter does not sample them.

Decomposition:
- Shared package (constant and typedef only, no logic):
  - CDB_PACKET typedef {valid, Tag, Value}.
  - FU index constants FU_ALU0 = 0, FU_ALU1 = 1, FU_MEM = 2.
  - TAG_W, derived from ROB_SIZE.
- One sub-module, rr_arbiter #(N): inputs req[N] and ptr; output one-hot gnt[N] and gnt_idx. Purely combinational, reused by later issue-select logic.

Test Plan:
- Reset: drive reset=0 for 2 cycles with fu_valid=3'b111 -> cdb_valid=0 and all outputs 0. Release reset -> fu_ready=3'b111.
- Single result: FU1 sends tag 5, value 0xDEAD at edge t -> cdb_valid=1, cdb_tag=5, cdb_value=0xDEAD, cdb_src=1 in cycle t+2 only. rr_ptr becomes 2.
- Contention: all three FUs valid at the same edge with tags 1/2/3, rr_ptr=0 -> CDB tags 1, 2, 3 on three consecutive cycles. fu_ready[1] and fu_ready[2] are 0 while their entries wait.
- Back-to-back: only FU0 sends tags 7, 8, 9 on consecutive cycles -> fu_ready[0] stays 1 and CDB shows 7, 8, 9 on consecutive cycles.
- Flush: hold FU2 tag 4 and FU0 tag 6, then assert flush for 1 cycle -> no CDB broadcast of 4 or 6, and fu_ready=0 during the flush cycle.
- Reset mid-operation: reset=0 while cdb_valid=1 and two holds are pending -> next cycle cdb_valid=0 and no pending entry is ever broadcast.
